// File: rtl/nlfsr_masked_perm_if.sv
// Handshake and data bundle between the masked TinyJAMBU datapath controller
// (master), the randomness source and the permutation engine (slave).
//
// Signals (widths follow SHARES and RND_W):
//   start       master -> engine   begin a permutation (sampled only when idle)
//   num_steps   master -> engine   number of W-bit steps, captured with start
//   state_in    master -> engine   initial shared state, share j at [j*128 +: 128]
//   key_in      master -> engine   shared key, same layout, stable while busy
//   rand_in     source -> engine   fresh randomness for one step
//   rand_valid  source -> engine   rand_in holds a fresh word
//   rand_ready  engine -> source   engine takes rand_in this cycle
//   busy        engine -> master   permutation in progress
//   done        engine -> master   one-cycle completion pulse
//   state_out   engine -> master   shared state register, layout as state_in
interface nlfsr_masked_perm_if #(
  parameter int SHARES = 3,
  parameter int RND_W  = 96
);
  logic                    start;
  logic [11:0]             num_steps;
  logic [SHARES*128-1:0]   state_in;
  logic [SHARES*128-1:0]   key_in;
  logic [RND_W-1:0]        rand_in;
  logic                    rand_valid;
  logic                    rand_ready;
  logic                    busy;
  logic                    done;
  logic [SHARES*128-1:0]   state_out;

  modport master (
    output start, num_steps, state_in, key_in, rand_in, rand_valid,
    input  rand_ready, busy, done, state_out
  );

  modport slave (
    input  start, num_steps, state_in, key_in, rand_in, rand_valid,
    output rand_ready, busy, done, state_out
  );
endinterface

// File: rtl/nlfsr_masked_perm_ctrl.sv
// Masked TinyJAMBU permutation engine. Holds a (SEC_ORDER+1)-share 128-bit
// NLFSR state and advances it STEP_WIDTH rounds per step. The nonlinear tap
// of every round is a nand_HPC2 gadget fed from a per-step fresh-randomness
// register; the engine waits GADGET_LAT cycles per step with gadget inputs
// frozen, and requests the next step's randomness in the last cycle of the
// current one so a continuous source gives zero bubbles.
//
// Ports:
//   clk     clock
//   rst     synchronous active-high reset (aborts, clears state, no done)
//   bus_if  slave side of nlfsr_masked_perm_if (start/num_steps/state/key,
//           randomness handshake, busy/done, state_out)
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start; state_out holds the last result
// WAIT_RND | rand_ready high, waiting for fresh randomness of this step
// EVAL     | gadgets evaluating; latency counter 0..GADGET_LAT-1
// DONE     | one-cycle done pulse, then back to IDLE
module nlfsr_masked_perm_ctrl #(
  parameter int SEC_ORDER  = 2,
  parameter int STEP_WIDTH = 32,
  parameter int GADGET_LAT = 2,
  parameter int RND_W      = STEP_WIDTH*SEC_ORDER*(SEC_ORDER+1)/2
) (
  input  logic                 clk,
  input  logic                 rst,
  nlfsr_masked_perm_if.slave   bus_if
);

  localparam int SHARES = SEC_ORDER + 1;
  localparam int RPG    = SEC_ORDER*(SEC_ORDER+1)/2;   // fresh bits per gadget
  localparam int LAT_W  = (GADGET_LAT > 1) ? $clog2(GADGET_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(GADGET_LAT-1);

  typedef enum logic [1:0] {IDLE, WAIT_RND, EVAL, DONE} state_e;

  state_e                fsm_q;
  logic [127:0]          s_q [SHARES];
  logic [RND_W-1:0]      fresh_q;
  logic [11:0]           num_q;
  logic [11:0]           step_q;
  logic [LAT_W-1:0]      lat_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  rdy_q;

  logic [STEP_WIDTH-1:0] fb_d [SHARES];
  logic [6:0]            key_off;
  logic                  last_lat;
  logic                  final_step;
  logic                  next_final;

  // Index of the fresh bit shared by the share pair (x, y), x != y,
  // enumerating unordered pairs row by row.
  function automatic int pair_idx(input int x, input int y);
    int lo;
    int hi;
    lo = (x < y) ? x : y;
    hi = (x < y) ? y : x;
    return lo*SHARES - (lo*(lo+1))/2 + (hi - lo - 1);
  endfunction

  assign last_lat   = (lat_q == LAT_LAST);
  assign final_step = (step_q + 12'd1 == num_q);
  assign next_final = (step_q + 12'd2 == num_q);

  // Key bit for round (step*W + i) is key[(off + i) mod 128]; rotating each
  // key share right by off keeps the per-bit index constant.
  always_comb begin
    logic [127:0]      k_sh;
    logic [127:0]      k_rot;
    logic [SHARES-1:0] a;
    logic [SHARES-1:0] b;
    logic              c;
    logic              r;
    k_sh    = '0;
    k_rot   = '0;
    a       = '0;
    b       = '0;
    c       = 1'b0;
    r       = 1'b0;
    key_off = 7'(int'(step_q) * STEP_WIDTH);
    for (int j = 0; j < SHARES; j++) fb_d[j] = '0;
    for (int i = 0; i < STEP_WIDTH; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        a[j] = s_q[j][70+i];
        b[j] = s_q[j][85+i];
      end
      for (int j = 0; j < SHARES; j++) begin
        // HPC2 output share j: a_j b_j ^ sum_k (~a_j r_jk ^ a_j (b_k ^ r_jk)).
        // Only share j of a meets other shares of b, always through r_jk.
        c = a[j] & b[j];
        for (int k = 0; k < SHARES; k++) begin
          if (k != j) begin
            r = fresh_q[i*RPG + pair_idx(j, k)];
            c = c ^ (~a[j] & r) ^ (a[j] & (b[k] ^ r));
          end
        end
        // NAND: invert a single share of the AND result.
        if (j == 0) c = ~c;
        k_sh  = bus_if.key_in[j*128 +: 128];
        k_rot = (k_sh >> key_off) | (k_sh << (8'd128 - {1'b0, key_off}));
        fb_d[j][i] = s_q[j][i] ^ s_q[j][47+i] ^ s_q[j][91+i] ^ c ^ k_rot[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
      fresh_q <= '0;
      num_q   <= '0;
      step_q  <= '0;
      lat_q   <= '0;
      for (int j = 0; j < SHARES; j++) s_q[j] <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus_if.start) begin
            for (int j = 0; j < SHARES; j++) s_q[j] <= bus_if.state_in[j*128 +: 128];
            num_q  <= bus_if.num_steps;
            step_q <= '0;
            if (bus_if.num_steps == 12'd0) begin
              fsm_q  <= DONE;
              done_q <= 1'b1;
            end else begin
              fsm_q  <= WAIT_RND;
              busy_q <= 1'b1;
              rdy_q  <= 1'b1;
            end
          end
        end

        WAIT_RND: begin
          if (bus_if.rand_valid) begin
            fresh_q <= bus_if.rand_in;
            lat_q   <= '0;
            fsm_q   <= EVAL;
            // With single-cycle gadgets the first EVAL cycle is already the
            // prefetch cycle.
            rdy_q   <= (GADGET_LAT == 1) && !final_step;
          end
        end

        EVAL: begin
          if (last_lat) begin
            for (int j = 0; j < SHARES; j++) s_q[j] <= {fb_d[j], s_q[j][127:STEP_WIDTH]};
            step_q <= step_q + 12'd1;
            if (final_step) begin
              fsm_q  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              rdy_q  <= 1'b0;
            end else if (bus_if.rand_valid) begin
              fresh_q <= bus_if.rand_in;
              lat_q   <= '0;
              rdy_q   <= (GADGET_LAT == 1) && !next_final;
            end else begin
              fsm_q <= WAIT_RND;
              rdy_q <= 1'b1;
            end
          end else begin
            lat_q <= lat_q + 1'b1;
            rdy_q <= (lat_q + 1'b1 == LAT_LAST) && !final_step;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          fsm_q  <= IDLE;
        end

        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign bus_if.rand_ready = rdy_q;
  assign bus_if.busy       = busy_q;
  assign bus_if.done       = done_q;

  for (genvar g = 0; g < SHARES; g++) begin : g_out
    assign bus_if.state_out[g*128 +: 128] = s_q[g];
  end

endmodule

// File: doc/nlfsr_masked_perm_ctrl.md
Name: nlfsr_masked_perm_ctrl

Overview:
- Parametrised masked TinyJAMBU permutation engine: d-th order HPC2-masked 128-bit NLFSR that holds its own shared state and steps it by STEP_WIDTH bits per step.
- Handles the round count, fresh-randomness handshake and gadget-latency stalls.
- Generalises the fixed 32-bit, 2nd-order combinational feedback core into a sequential unit sitting between the masked TinyJAMBU datapath controller and the randomness source.

Parameters:
- SEC_ORDER, 2, masking order d; SHARES = SEC_ORDER+1.
- STEP_WIDTH, 32, feedback bits per step W; legal values 1, 2, 4, 8, 16, 32.
- GADGET_LAT, 2, clock cycles for one nand_HPC2 evaluation; minimum 1.
- RND_W, STEP_WIDTH*SEC_ORDER*(SEC_ORDER+1)/2, derived fresh bits per step (96 at default).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin permutation; sampled only in IDLE.
- num_steps  in  12  number of W-bit steps; sampled at start.
- state_in  in  SHARES*128  initial shared state; share j at [j*128+:128].
- key_in  in  SHARES*128  shared key; must stay stable while busy.
- rand_in  in  RND_W  fresh randomness.
- rand_valid  in  1  rand_in valid.
- rand_ready  out  1  engine accepts rand_in this cycle.
- busy  out  1  permutation in progress.
- done  out  1  one-cycle completion pulse.
- state_out  out  SHARES*128  shared state register, same layout as state_in.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: FSM=IDLE; busy=0, done=0, rand_ready=0; state registers of all shares=0; step counter=0; fresh register=0.
- Reset asserted mid-operation: abort, no done pulse, state cleared.
- FSM states: IDLE, WAIT_RND, EVAL, DONE.
- IDLE:
  - On start: load state_in, capture num_steps, clear step counter.
  - Next state is DONE if num_steps==0 (state unchanged), else WAIT_RND.
- WAIT_RND:
  - rand_ready=1.
  - On rand_valid: capture rand_in into fresh register, clear latency counter, go to EVAL.
  - Without rand_valid, stay in WAIT_RND; state held.
- EVAL:
  - Latency counter runs 0..GADGET_LAT-1.
  - Gadget inputs (state, fresh register) held constant throughout.
  - On the last cycle:
    - Every share j shifts right by W: s_j <= {fb_j, s_j[127:W]}.
    - Step counter increments.
    - If it was the final step, go to DONE.
  - Prefetch: in the last EVAL cycle of a non-final step, rand_ready=1.
    - If rand_valid, the next step's fresh is captured and FSM re-enters EVAL directly (zero bubble).
    - Otherwise FSM goes to WAIT_RND.
- Feedback, bit i in 0..W-1, share j:
  - fb_j[i] = s_j[i] ^ s_j[47+i] ^ s_j[91+i] ^ n_j[i] ^ k_j[(step*W+i) mod 128].
  - n[i] = masked NAND(s[70+i], s[85+i]) via nand_HPC2.
  - Gadget i consumes fresh bits [i*SEC_ORDER*(SEC_ORDER+1)/2 +: SEC_ORDER*(SEC_ORDER+1)/2].
  - Key offset is the low bits of step*W, wrapping every 128/W steps.
- DONE:
  - done=1 for exactly one cycle, busy=0; go to IDLE.
  - state_out is valid in DONE and IDLE.
- busy: 1 in WAIT_RND and EVAL only.
- start while not in IDLE: ignored.
- rand_valid outside rand_ready cycles: ignored; no randomness is consumed.
- Timing, randomness always valid: start in cycle t, done in cycle t+2+N*GADGET_LAT.
- Unmasking: XOR of all shares of state_out equals unmasked TinyJAMBU after N*W rounds.
- No share recombination is allowed anywhere except inside the gadgets.

Test Plan:
- Golden model, d=2, W=32, GADGET_LAT=2:
  - Random shares of a known state/key, N=32 (1024 rounds), rand_valid held 1.
  - Required: XOR(state_out shares) equals the unmasked TinyJAMBU golden model; done in cycle t+66; one pulse.
- Zero steps: num_steps=0 -> done in cycle t+1, state_out == state_in, rand_ready never asserted.
- Randomness stalls: rand_valid deasserted for 5 cycles before step 3 and in the prefetch cycle of step 10.
  - Required: state frozen during stalls, busy held, final result identical to the no-stall run, done delayed by exactly the stall cycles.
- Reset mid-operation: rst at step 10 -> next cycle busy=0, done=0, state_out=0; a subsequent start with N=32 gives the golden result.
- Ignored start: start pulsed during EVAL and rand_valid pulsed in IDLE -> no effect on result or timing.
- Alternate configuration, SEC_ORDER=1, STEP_WIDTH=8 (RND_W=8), N=128 -> unmasked golden match; key index wraps after 16 steps; done at t+258.
